// File: rtl/control_pipe.sv
// control_pipe: RV32I opcode decode in ID plus EX/MEM/WB control pipeline with hazard, flush and freeze handling
module control_pipe #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  ex_valid,
    output logic                  mem_valid,
    output logic                  wb_valid,
    output logic [9:0]            ex_ctrl,
    output logic [9:0]            mem_ctrl,
    output logic [9:0]            wb_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  ex_illegal,
    output logic                  wb_reg_we,
    output logic                  stall_id,
    output logic                  flush_id
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [9:0]            dec_ctrl;
    logic                  dec_illegal;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  load_use;
    logic                  flush;
    logic                  ex_load;
    logic                  ex_valid_q, ex_valid_d;
    logic [9:0]            ex_ctrl_q, ex_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic                  ex_illegal_q, ex_illegal_d;
    logic                  mem_valid_q, wb_valid_q;
    logic [9:0]            mem_ctrl_q, wb_ctrl_q;
    logic [REG_ADDR_W-1:0] mem_rd_q, wb_rd_q;

    // Decode the ID opcode into its control word and which source registers it reads
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b0;
        case (id_opcode)
            OP_R:      begin dec_ctrl = 10'h088; uses_rs2 = 1'b1; end
            OP_IALU:   dec_ctrl = 10'h2A8;
            OP_LUI:    begin dec_ctrl = 10'h0A0; uses_rs1 = 1'b0; end
            OP_AUIPC:  begin dec_ctrl = 10'h0B0; uses_rs1 = 1'b0; end
            OP_LOAD:   dec_ctrl = 10'h0A2;
            OP_STORE:  begin dec_ctrl = 10'h024; uses_rs2 = 1'b1; end
            OP_BRANCH: begin dec_ctrl = 10'h001; uses_rs2 = 1'b1; end
            OP_JALR:   dec_ctrl = 10'h1E1;
            OP_JAL:    begin dec_ctrl = 10'h1F1; uses_rs1 = 1'b0; end
            default:   begin dec_illegal = 1'b1; uses_rs1 = 1'b0; end
        endcase
    end

    assign load_use = id_valid & ex_valid_q & ex_ctrl_q[1] & (ex_rd_q != '0) &
                      ((uses_rs1 & (id_rs1 == ex_rd_q)) | (uses_rs2 & (id_rs2 == ex_rd_q)));
    assign flush    = ex_valid_q & branch_taken;
    assign ex_load  = id_valid & ~flush & ~load_use & ~(dec_illegal & !ILLEGAL_TRAP);

    // Next EX entry: the decoded ID instruction, or a bubble on flush, load-use, dropped illegal or empty ID
    always_comb begin
        ex_valid_d   = ex_load;
        ex_ctrl_d    = ex_load ? dec_ctrl : '0;
        ex_rd_d      = ex_load ? id_rd : '0;
        ex_illegal_d = ex_load & dec_illegal;
    end

    // Stage registers advance together only when data memory can complete; otherwise the whole pipe freezes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_rd_q      <= '0;
            ex_illegal_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_ctrl_q   <= '0;
            mem_rd_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_ctrl_q    <= '0;
            wb_rd_q      <= '0;
        end else if (mem_ready) begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rd_q      <= ex_rd_d;
            ex_illegal_q <= ex_illegal_d;
            mem_valid_q  <= ex_valid_q;
            mem_ctrl_q   <= ex_ctrl_q;
            mem_rd_q     <= ex_rd_q;
            wb_valid_q   <= mem_valid_q;
            wb_ctrl_q    <= mem_ctrl_q;
            wb_rd_q      <= mem_rd_q;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rd      = ex_rd_q;
    assign ex_illegal = ex_illegal_q;
    assign mem_valid  = mem_valid_q;
    assign mem_ctrl   = mem_ctrl_q;
    assign mem_rd     = mem_rd_q;
    assign wb_valid   = wb_valid_q;
    assign wb_ctrl    = wb_ctrl_q;
    assign wb_rd      = wb_rd_q;
    assign wb_reg_we  = wb_valid_q & wb_ctrl_q[7] & (wb_rd_q != '0);
    // A memory wait holds ID even in reset-free operation; reset forces both handshakes low
    assign stall_id   = rst_n & (~mem_ready | (~flush & load_use));
    assign flush_id   = mem_ready & flush;
endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined successor to the single-cycle opcode control decoder. Decodes the full RV32I 7-bit opcode into the 10-bit control word in ID, then carries that word and the destination register through the EX, MEM and WB pipeline registers.
- Detects load-use hazards and inserts bubbles. Flushes on a taken branch or jump. Freezes the whole pipe while data memory is not ready.
- Sits between the fetch/ID stage and the datapath stage registers of the pipelined core.

Parameters:
- REG_ADDR_W, 5: width of the register index fields.
- ILLEGAL_TRAP, 1: 1 = an illegal opcode travels down the pipe as a valid entry with its illegal flag set. 0 = an illegal opcode is converted into a bubble.

Ports:
- clk  in  1  core clock; every register updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  7  instr[6:0].
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register fields of the ID instruction.
- branch_taken  in  1  EX-stage resolution: the branch/jump currently in EX redirects the PC.
- mem_ready  in  1  data memory can complete this cycle.
- ex_valid, mem_valid, wb_valid  out  1 each  stage-occupied flags.
- ex_ctrl, mem_ctrl, wb_ctrl  out  10 each  control words per stage.
- ex_rd, mem_rd, wb_rd  out  REG_ADDR_W each  destination register per stage.
- ex_illegal  out  1  the EX entry is an illegal opcode.
- wb_reg_we  out  1  equals wb_valid & wb_ctrl[7] & (wb_rd != 0); combinational.
- stall_id  out  1  fetch/ID must hold this cycle; combinational.
- flush_id  out  1  fetch/ID must discard its instruction; combinational.

Behaviour:
- Control bits: [0] branch, [1] mem_read/mem_to_reg, [2] mem_write, [3] alu uses funct3, [4] alu_src1 = pc, [5] alu_src2 = imm, [6] result = pc+4, [7] reg_write, [8] unconditional, [9] I-type.
- Decode is combinational and fully specified. Every bit not listed below is 0; no latches.
- Decode per opcode (bits listed are the ones set to 1):
  - 0110011 R: [3,7].
  - 0010011 I-ALU: [3,5,7,9].
  - 0110111 LUI: [5,7].
  - 0010111 AUIPC: [4,5,7].
  - 0000011 load: [1,5,7].
  - 0100011 store: [2,5].
  - 1100011 branch: [0].
  - 1100111 JALR: [0,5,6,7,8].
  - 1101111 JAL: [0,4,5,6,7,8].
  - Any other opcode is illegal: control word 0, illegal = 1.
- Operand use:
  - uses_rs1 for every legal opcode except LUI, AUIPC and JAL.
  - uses_rs2 for R-type, store and branch only.
- load_use = ex_valid & ex_ctrl[1] & (ex_rd != 0) & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)) & id_valid.
- Per-cycle priority, evaluated in this order:
  1. mem_ready = 0: every stage register holds. stall_id = 1, flush_id = 0. A pending branch_taken is not acted on; EX holds it until mem_ready = 1.
  2. ex_valid & branch_taken: ID→EX loads a bubble, flush_id = 1, stall_id = 0. EX→MEM and MEM→WB advance. Flush takes precedence over load_use.
  3. load_use: ID→EX loads a bubble, stall_id = 1. EX→MEM and MEM→WB advance.
  4. Otherwise: all stages advance. ID→EX loads valid = id_valid together with the decoded control word, id_rd and the illegal flag.
- A bubble means valid = 0, ctrl = 0, rd = 0, illegal = 0.
- With ILLEGAL_TRAP = 0, an illegal ID instruction loads a bubble into EX, and stall_id/flush_id are not asserted because of it.
- Invalid entries (id_valid = 0) still advance but carry ctrl = 0.
- Latency: the control word for an ID instruction appears on ex_ctrl 1 cycle later, on mem_ctrl 2 cycles later and on wb_ctrl 3 cycles later, in the absence of stalls.
- Reset: asynchronous, active-low. All valid flags, control words, rd fields and ex_illegal clear to 0 immediately, regardless of clk.
  - Consequently stall_id = 0, flush_id = 0 and wb_reg_we = 0 during reset.
  - An in-flight instruction is dropped. The first rising edge after release samples ID normally.

Test Plan:
- Reset mid-stream: assert rst_n = 0 between edges while all stages hold an R-type → every output reads 0 immediately, with no clock edge needed.
- Straight line: feed ADDI (0010011, rd = 5), then LUI, then JAL on consecutive cycles with mem_ready = 1 → ex_ctrl reads 0x2A8, 0x0A0, 0x1F1 on successive cycles. wb_reg_we = 1 three cycles after each instruction enters ID.
- Load-use: LW (rd = 3) followed by ADD (rs2 = 3) → the cycle the LW is in EX has stall_id = 1 and loads a bubble into EX. The ADD reaches EX one cycle later. With rd = 0 instead, no stall occurs.
- Branch flush: BEQ in EX with branch_taken = 1 while ID holds an SW that load_use would also stall → flush_id = 1, stall_id = 0, next ex_valid = 0, and mem_ctrl = 0x001.
- Memory wait: hold mem_ready = 0 for 3 cycles with a SW in MEM and branch_taken = 1 → all stage outputs stay frozen, stall_id = 1, flush_id = 0. When mem_ready returns to 1, the flush occurs on that cycle.
- Illegal opcode 1111111:
  - ILLEGAL_TRAP = 1 → ex_valid = 1, ex_illegal = 1, ex_ctrl = 0.
  - ILLEGAL_TRAP = 0 → ex_valid = 0, ex_illegal = 0.
